// File: rtl/lcd_text_driver_if.sv
// Generator-side and LCD-side signals of the text driver, bundled so the
// driver sees them as one port.
interface lcd_text_driver_if;
    logic [4:0] index;
    logic [7:0] char_in;
    logic       lcd_e;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    modport master (output index, lcd_e, lcd_rs, lcd_rw, lcd_data, input char_in);
    modport slave  (input index, lcd_e, lcd_rs, lcd_rw, lcd_data, output char_in);
endinterface

// File: rtl/lcd_text_driver.sv
// HD44780 2x16 text driver: one-time init, then endless refresh of both lines.
// Define LCD_INIT_REPEAT_EN to issue Function Set three times during init.
module lcd_text_driver #(
    parameter int STEP_CYCLES    = 50,
    parameter int E_WIDTH        = 12,
    parameter int POWERUP_CYCLES = 20000,
    parameter int CLEAR_CYCLES   = 2000
) (
    input  logic               clk,
    input  logic               rst,
    lcd_text_driver_if.master  bus,
    output logic               init_done,
    output logic               frame_done
);

    localparam int CNT_MAX = (POWERUP_CYCLES > STEP_CYCLES + CLEAR_CYCLES) ?
                             POWERUP_CYCLES : STEP_CYCLES + CLEAR_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(POWERUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(STEP_CYCLES + CLEAR_CYCLES - 1);
    // lcd_e is registered, so it is armed one count early to be high on cnt 4..
    localparam logic [CNT_W-1:0] E_ARM     = CNT_W'(3);
    localparam logic [CNT_W-1:0] E_DISARM  = CNT_W'(3 + E_WIDTH);
    localparam logic [CNT_W-1:0] IDX_CNT   = CNT_W'(0);
    localparam logic [CNT_W-1:0] LOAD_CNT  = CNT_W'(2);

    typedef enum logic [3:0] {
        PWRUP, FSET, DISP, ENTRY, CLR, ADDR1, WR1, ADDR2, WR2
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] step_last;
    logic             step_end;
    logic [3:0]       char_cnt;
    logic [7:0]       cmd_byte;
    logic             fset_last;
    logic             is_write;

`ifdef LCD_INIT_REPEAT_EN
    logic [1:0] fset_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            fset_cnt <= '0;
        else if (state == FSET && step_end)
            fset_cnt <= fset_cnt + 2'd1;
    end

    assign fset_last = (fset_cnt == 2'd2);
`else
    assign fset_last = 1'b1;
`endif

    assign is_write   = (state == WR1) || (state == WR2);
    assign step_end   = (cnt == step_last);
    assign bus.lcd_rw = 1'b0;

    always_comb begin
        step_last = STEP_LAST;
        cmd_byte  = 8'h00;
        case (state)
            PWRUP: step_last = PWR_LAST;
            FSET:  cmd_byte  = 8'h38;
            DISP:  cmd_byte  = 8'h0C;
            ENTRY: cmd_byte  = 8'h06;
            CLR: begin
                cmd_byte  = 8'h01;
                step_last = CLR_LAST;
            end
            ADDR1: cmd_byte  = 8'h80;
            ADDR2: cmd_byte  = 8'hC0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= PWRUP;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (step_end) begin
            case (state)
                PWRUP:   state_next = FSET;
                FSET:    state_next = fset_last ? DISP : FSET;
                DISP:    state_next = ENTRY;
                ENTRY:   state_next = CLR;
                CLR:     state_next = ADDR1;
                ADDR1:   state_next = WR1;
                WR1:     state_next = (char_cnt == 4'd15) ? ADDR2 : WR1;
                ADDR2:   state_next = WR2;
                WR2:     state_next = (char_cnt == 4'd15) ? ADDR1 : WR2;
                default: state_next = PWRUP;
            endcase
        end
    end

    // char_in is latched only at cnt==2, so later changes cannot disturb the strobe
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            char_cnt     <= 4'd0;
            bus.index    <= 5'd0;
            bus.lcd_e    <= 1'b0;
            bus.lcd_rs   <= 1'b0;
            bus.lcd_data <= 8'h00;
            init_done    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            cnt <= step_end ? '0 : cnt + CNT_W'(1);

            if (step_end && is_write)
                char_cnt <= char_cnt + 4'd1;

            if (cnt == IDX_CNT) begin
                if (state == WR1)
                    bus.index <= {1'b0, char_cnt};
                else if (state == WR2)
                    bus.index <= {1'b1, char_cnt};
            end

            if (cnt == LOAD_CNT && state != PWRUP) begin
                bus.lcd_rs   <= is_write;
                bus.lcd_data <= is_write ? bus.char_in : cmd_byte;
            end

            bus.lcd_e <= (state != PWRUP) && (cnt >= E_ARM) && (cnt < E_DISARM);

            if (state_next == ADDR1)
                init_done <= 1'b1;

            frame_done <= (state == WR2) && (state_next == ADDR1);
        end
    end

endmodule
